// File: rtl/sbqm_pkg.sv
// Shared widths, limits and types for the queue-management slice
// (queue counter producer and wait-time lookup consumer).
package sbqm_pkg;

    localparam int PCOUNT_W         = 3;
    localparam int TCOUNT_W         = 2;
    localparam int MAX_COUNT        = 7;
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int DEBOUNCE_CNT_W   = 4;

    typedef logic [PCOUNT_W-1:0] pcount_t;
    typedef logic [TCOUNT_W-1:0] tcount_t;

    // Per-cycle decision taken by the customer counter.
    typedef enum logic [1:0] {
        UPD_HOLD  = 2'd0,
        UPD_INC   = 2'd1,
        UPD_DEC   = 2'd2,
        UPD_SERVE = 2'd3
    } upd_e;

endpackage

// File: rtl/sbqm_sensor_filter.sv
// Photocell front end: 2-FF synchronizer, debounce filter on the accepted
// level, and a one-cycle registered pulse on each accepted 0->1 transition.
module sbqm_sensor_filter
    import sbqm_pkg::*;
#(
    parameter int DEBOUNCE = sbqm_pkg::DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sens,
    output logic evt
);

    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE - 1);
    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_ZERO = DEBOUNCE_CNT_W'(0);
    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_ONE  = DEBOUNCE_CNT_W'(1);

    logic                      sync1_r;
    logic                      sync2_r;
    logic                      lvl_r;
    logic                      lvl_d_r;
    logic                      evt_r;
    logic [DEBOUNCE_CNT_W-1:0] cnt_r;
    logic                      lvl_s;
    logic [DEBOUNCE_CNT_W-1:0] cnt_s;
    logic                      rise_s;

    // Two-stage synchronizer for the asynchronous photocell.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sens;
            sync2_r <= sync1_r;
        end
    end

    // Debounce state register: accepted level, stability counter, level history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_r   <= 1'b0;
            lvl_d_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            lvl_r   <= lvl_s;
            lvl_d_r <= lvl_r;
            cnt_r   <= cnt_s;
        end
    end

    // Debounce next state: a level is accepted after DEBOUNCE differing samples in a row.
    always_comb begin
        lvl_s = lvl_r;
        cnt_s = cnt_r;
        if (sync2_r == lvl_r) begin
            cnt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            lvl_s = ~lvl_r;
            cnt_s = CNT_ZERO;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
    end

    // Rise detect on the accepted level; falling edges carry no event.
    always_comb begin
        rise_s = lvl_r & ~lvl_d_r;
    end

    // Registered event pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_r <= 1'b0;
        end else begin
            evt_r <= rise_s;
        end
    end

    assign evt = evt_r;

endmodule

// File: rtl/sbqm_queue_counter.sv
// Saturating customer counter fed by the back (arrival) and front (departure)
// photocells, plus the registered teller count read by the wait-time lookup.
module sbqm_queue_counter
    import sbqm_pkg::*;
#(
    parameter int PCOUNT_W  = sbqm_pkg::PCOUNT_W,
    parameter int TCOUNT_W  = sbqm_pkg::TCOUNT_W,
    parameter int MAX_COUNT = sbqm_pkg::MAX_COUNT,
    parameter int DEBOUNCE  = sbqm_pkg::DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sens_back,
    input  logic                sens_front,
    input  logic [TCOUNT_W-1:0] tellers_in,
    output logic [PCOUNT_W-1:0] pcount,
    output logic [TCOUNT_W-1:0] tcount,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [PCOUNT_W-1:0] P_MAX  = PCOUNT_W'(MAX_COUNT);
    localparam logic [PCOUNT_W-1:0] P_ZERO = PCOUNT_W'(0);
    localparam logic [PCOUNT_W-1:0] P_ONE  = PCOUNT_W'(1);

    logic                arr_s;
    logic                dep_s;
    upd_e                upd_s;
    logic                ovf_s;
    logic                udf_s;
    logic [PCOUNT_W-1:0] pcount_s;
    logic                full_s;
    logic                empty_s;

    logic [PCOUNT_W-1:0] pcount_r;
    logic [TCOUNT_W-1:0] tcount_r;
    logic                full_r;
    logic                empty_r;
    logic                ovf_r;
    logic                udf_r;

    sbqm_sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_back (
        .clk   (clk),
        .rst_n (rst_n),
        .sens  (sens_back),
        .evt   (arr_s)
    );

    sbqm_sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_front (
        .clk   (clk),
        .rst_n (rst_n),
        .sens  (sens_front),
        .evt   (dep_s)
    );

    // Event arbitration; a simultaneous arrival and departure never changes the count.
    always_comb begin
        upd_s = UPD_HOLD;
        ovf_s = 1'b0;
        udf_s = 1'b0;
        case ({arr_s, dep_s})
            2'b10: begin
                if (pcount_r < P_MAX) begin
                    upd_s = UPD_INC;
                end else begin
                    ovf_s = 1'b1;
                end
            end
            2'b01: begin
                if (pcount_r > P_ZERO) begin
                    upd_s = UPD_DEC;
                end else begin
                    udf_s = 1'b1;
                end
            end
            2'b11:   upd_s = UPD_SERVE;
            default: upd_s = UPD_HOLD;
        endcase
    end

    // Next count and flags, so full/empty stay coherent with pcount.
    always_comb begin
        pcount_s = pcount_r;
        case (upd_s)
            UPD_INC: pcount_s = pcount_r + P_ONE;
            UPD_DEC: pcount_s = pcount_r - P_ONE;
            default: pcount_s = pcount_r;
        endcase
        if (pcount_s == P_MAX) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        if (pcount_s == P_ZERO) begin
            empty_s = 1'b1;
        end else begin
            empty_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcount_r <= P_ZERO;
            tcount_r <= TCOUNT_W'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            pcount_r <= pcount_s;
            tcount_r <= tellers_in;
            full_r   <= full_s;
            empty_r  <= empty_s;
            ovf_r    <= ovf_s;
            udf_r    <= udf_s;
        end
    end

    assign pcount    = pcount_r;
    assign tcount    = tcount_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign overflow  = ovf_r;
    assign underflow = udf_r;

endmodule
